// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/writeback stage.
// Opcodes, FSM states, flag bit positions and the instruction bundle.
package exec_pkg;

  localparam int DW      = 16;
  localparam int AW      = 4;
  localparam int MUL_CYC = 16;
  localparam int CW      = $clog2(MUL_CYC);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SWP = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rm;
    logic [DW-1:0] imm;
  } instr_t;

endpackage

// File: rtl/exec_if.sv
// Instruction handshake plus register-file read/write bus.
// slave = execute stage side, master = decoder/regfile side.
interface exec_if;
  import exec_pkg::*;

  logic          Instr_Valid;
  logic          Instr_Ready;
  logic [3:0]    Instr_Op;
  logic [AW-1:0] Instr_Rd;
  logic [AW-1:0] Instr_Rs;
  logic [AW-1:0] Instr_Rm;
  logic [DW-1:0] Instr_Imm;
  logic [AW-1:0] Rd_Addr;
  logic [AW-1:0] Rs_Addr;
  logic [AW-1:0] Rm_Addr;
  logic [DW-1:0] Rd_Out;
  logic [DW-1:0] Rs_Out;
  logic [DW-1:0] Rm_Out;
  logic          Rd_Wen;
  logic          Rs_Wen;
  logic [DW-1:0] Rd_Data;
  logic [DW-1:0] Rs_Data;

  modport slave (
    input  Instr_Valid, Instr_Op,
    input  Instr_Rd, Instr_Rs, Instr_Rm,
    input  Instr_Imm,
    input  Rd_Out, Rs_Out, Rm_Out,
    output Instr_Ready,
    output Rd_Addr, Rs_Addr, Rm_Addr,
    output Rd_Wen, Rs_Wen,
    output Rd_Data, Rs_Data
  );

  modport master (
    output Instr_Valid, Instr_Op,
    output Instr_Rd, Instr_Rs, Instr_Rm,
    output Instr_Imm,
    output Rd_Out, Rs_Out, Rm_Out,
    input  Instr_Ready,
    input  Rd_Addr, Rs_Addr, Rm_Addr,
    input  Rd_Wen, Rs_Wen,
    input  Rd_Data, Rs_Data
  );

endinterface

// File: rtl/seq_mul16.sv
// Iterative shift-add unsigned multiplier, DW x DW -> 2*DW.
// Ports: Clock, Reset_n, start, a, b in; busy, done, prod out.
module seq_mul16
  import exec_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] prod
);

  logic [DW-1:0]   mcand;
  logic [2*DW-1:0] acc;
  logic [CW-1:0]   cnt;
  logic [DW:0]     sum;

  // acc = {partial hi, remaining multiplier bits}; lsb picks add
  assign sum = {1'b0, acc[2*DW-1:DW]}
             + (acc[0] ? {1'b0, mcand} : '0);

  // high on the cycle whose closing edge does the last step
  assign done = busy && (cnt == CW'(MUL_CYC - 1));
  assign prod = acc;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{DW{1'b0}}, b};
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= {sum, acc[DW-1:1]};
      cnt <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_writeback_unit.sv
// Execute + writeback stage ahead of the dual-write register file.
// Ports: Clock, Reset_n, bus (exec_if.slave), Flags {N,Z,C,V}, Done.
module exec_writeback_unit
  import exec_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_n,
  exec_if.slave      bus,
  output logic [3:0] Flags,
  output logic       Done
);

  state_t          st, st_nx;
  instr_t          ins;
  logic [3:0]      fl_q, fl_nx;
  logic            fl_we;
  logic            hs;
  logic            rd_wen, rs_wen, done_c;
  logic [DW-1:0]   rd_data, rs_data;
  logic            mul_go, mul_busy, mul_done;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   a, b, r;
  logic [DW:0]     sum, dif;

  assign bus.Instr_Ready = (st == S_IDLE) && Reset_n;
  assign hs = bus.Instr_Valid && bus.Instr_Ready;

  assign bus.Rd_Addr = ins.rd;
  assign bus.Rs_Addr = ins.rs;
  assign bus.Rm_Addr = ins.rm;

  assign a = bus.Rs_Out;
  assign b = bus.Rm_Out;
  assign sum = {1'b0, a} + {1'b0, b};
  // carry-out of a + ~b + 1 is the no-borrow flag
  assign dif = {1'b0, a} + {1'b0, ~b} + 17'd1;

  // keep the regfile quiet while reset is held
  assign bus.Rd_Wen  = rd_wen && Reset_n;
  assign bus.Rs_Wen  = rs_wen && Reset_n;
  assign bus.Rd_Data = rd_data;
  assign bus.Rs_Data = rs_data;
  assign Done        = done_c && Reset_n;
  assign Flags       = fl_q;

  seq_mul16 u_mul (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .start   (mul_go),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod    (prod)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      st   <= S_IDLE;
      ins  <= '0;
      fl_q <= '0;
    end else begin
      st <= st_nx;
      if (hs) begin
        ins.op  <= bus.Instr_Op;
        ins.rd  <= bus.Instr_Rd;
        ins.rs  <= bus.Instr_Rs;
        ins.rm  <= bus.Instr_Rm;
        ins.imm <= bus.Instr_Imm;
      end
      if (fl_we)
        fl_q <= fl_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    rd_wen  = 1'b0;
    rs_wen  = 1'b0;
    rd_data = '0;
    rs_data = '0;
    done_c  = 1'b0;
    fl_we   = 1'b0;
    fl_nx   = fl_q;
    mul_go  = 1'b0;
    r       = '0;
    unique case (st)
      S_IDLE: begin
        if (hs)
          st_nx = S_EXEC;
      end
      S_EXEC: begin
        st_nx  = S_IDLE;
        done_c = 1'b1;
        unique case (1'b1)
          (ins.op == OP_MOV): begin
            rd_wen  = 1'b1;
            rd_data = b;
          end
          (ins.op == OP_ADD): begin
            r       = sum[DW-1:0];
            rd_wen  = 1'b1;
            rd_data = r;
            fl_we   = 1'b1;
            fl_nx[FN] = r[DW-1];
            fl_nx[FZ] = (r == '0);
            fl_nx[FC] = sum[DW];
            fl_nx[FV] = (a[DW-1] == b[DW-1])
                     && (r[DW-1] != a[DW-1]);
          end
          (ins.op == OP_SUB): begin
            r       = dif[DW-1:0];
            rd_wen  = 1'b1;
            rd_data = r;
            fl_we   = 1'b1;
            fl_nx[FN] = r[DW-1];
            fl_nx[FZ] = (r == '0);
            fl_nx[FC] = dif[DW];
            fl_nx[FV] = (a[DW-1] != b[DW-1])
                     && (r[DW-1] != a[DW-1]);
          end
          (ins.op == OP_AND),
          (ins.op == OP_OR),
          (ins.op == OP_XOR): begin
            if (ins.op == OP_AND)
              r = a & b;
            else if (ins.op == OP_OR)
              r = a | b;
            else
              r = a ^ b;
            rd_wen  = 1'b1;
            rd_data = r;
            fl_we   = 1'b1;
            fl_nx   = {r[DW-1], (r == '0), 2'b00};
          end
          (ins.op == OP_SWP): begin
            rd_wen  = (ins.rd != ins.rs);
            rs_wen  = (ins.rd != ins.rs);
            rd_data = a;
            rs_data = bus.Rd_Out;
          end
          (ins.op == OP_MUL): begin
            done_c = 1'b0;
            mul_go = !mul_busy;
            st_nx  = S_MUL;
          end
          (ins.op == OP_LDI): begin
            rd_wen  = 1'b1;
            rd_data = ins.imm;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        if (mul_done)
          st_nx = S_WB;
      end
      S_WB: begin
        st_nx   = S_IDLE;
        done_c  = 1'b1;
        // Rs keeps the low half when both names alias
        rd_wen  = (ins.rd != ins.rs);
        rs_wen  = 1'b1;
        rd_data = prod[2*DW-1:DW];
        rs_data = prod[DW-1:0];
        fl_we   = 1'b1;
        fl_nx   = {prod[2*DW-1], (prod == '0), 2'b00};
      end
      default: st_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Random + directed bench for exec_writeback_unit.
// Holds a register file and an arithmetic reference model.
module tb_exec_writeback_unit;
  import exec_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Flags;
  logic       Done;

  exec_if bus();

  exec_writeback_unit dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus),
    .Flags   (Flags),
    .Done    (Done)
  );

  always #5 Clock = ~Clock;

  logic [15:0] rf  [16];
  logic [15:0] mrf [16];
  logic [3:0]  mfl;
  int total = 0;
  int bad   = 0;
  int wen_ev = 0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  assign bus.Rd_Out = rf[bus.Rd_Addr];
  assign bus.Rs_Out = rf[bus.Rs_Addr];
  assign bus.Rm_Out = rf[bus.Rm_Addr];

  always @(posedge Clock) begin
    if (pl_en)
      rf[pl_a] <= pl_d;
    if (bus.Rd_Wen)
      rf[bus.Rd_Addr] <= bus.Rd_Data;
    if (bus.Rs_Wen)
      rf[bus.Rs_Addr] <= bus.Rs_Data;
    if (bus.Rd_Wen || bus.Rs_Wen)
      wen_ev <= wen_ev + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setreg(input logic [3:0] a,
                        input logic [15:0] d);
    @(negedge Clock);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge Clock);
    #1 pl_en = 1'b0;
    mrf[a] = d;
  endtask

  // reference: plain arithmetic on the architectural state
  task automatic model(input logic [3:0] op,
                       input logic [3:0] rd,
                       input logic [3:0] rs,
                       input logic [3:0] rm,
                       input logic [15:0] imm,
                       output logic erw,
                       output logic esw,
                       output int lat);
    logic [15:0] x, y, z, res;
    int s, sv;
    longint p;
    x = mrf[rd];
    y = mrf[rs];
    z = mrf[rm];
    erw = 1'b0;
    esw = 1'b0;
    lat = 1;
    case (op)
      1: begin mrf[rd] = z; erw = 1'b1; end
      2: begin
        s  = int'(y) + int'(z);
        sv = int'($signed(y)) + int'($signed(z));
        res = s[15:0];
        mrf[rd] = res;
        erw = 1'b1;
        mfl = {res[15], res == 16'd0, s > 65535,
               (sv > 32767) || (sv < -32768)};
      end
      3: begin
        s  = int'(y) - int'(z);
        sv = int'($signed(y)) - int'($signed(z));
        res = s[15:0];
        mrf[rd] = res;
        erw = 1'b1;
        mfl = {res[15], res == 16'd0, y >= z,
               (sv > 32767) || (sv < -32768)};
      end
      4, 5, 6: begin
        if (op == 4) res = y & z;
        else if (op == 5) res = y | z;
        else res = y ^ z;
        mrf[rd] = res;
        erw = 1'b1;
        mfl = {res[15], res == 16'd0, 2'b00};
      end
      7: begin
        if (rd != rs) begin
          mrf[rd] = y;
          mrf[rs] = x;
          erw = 1'b1;
          esw = 1'b1;
        end
      end
      8: begin
        p = longint'(y) * longint'(z);
        lat = 18;
        esw = 1'b1;
        erw = (rd != rs);
        if (rd != rs)
          mrf[rd] = p[31:16];
        mrf[rs] = p[15:0];
        mfl = {p[31], p[31:0] == 32'd0, 2'b00};
      end
      9: begin mrf[rd] = imm; erw = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [3:0] rd,
                       input logic [3:0] rs,
                       input logic [3:0] rm,
                       input logic [15:0] imm,
                       input bit keep);
    logic erw, esw;
    int lat, n, w0;
    bit ok;
    @(negedge Clock);
    chk("done_idle", 32'(Done), 32'd0);
    bus.Instr_Op    = op;
    bus.Instr_Rd    = rd;
    bus.Instr_Rs    = rs;
    bus.Instr_Rm    = rm;
    bus.Instr_Imm   = imm;
    bus.Instr_Valid = 1'b1;
    n = 0;
    while (!bus.Instr_Ready && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!bus.Instr_Ready) begin
      chk("accept_to", 32'd0, 32'd1);
      bus.Instr_Valid = 1'b0;
      return;
    end
    model(op, rd, rs, rm, imm, erw, esw, lat);
    w0 = wen_ev;
    @(posedge Clock);
    n = 0;
    ok = 1'b0;
    while (n < 40) begin
      @(negedge Clock);
      n++;
      if (n == 1) begin
        chk("rdy_busy", 32'(bus.Instr_Ready), 32'd0);
        if (!keep)
          bus.Instr_Valid = 1'b0;
      end
      if (Done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("latency", ok ? 32'(n) : 32'd0, 32'(lat));
    if (ok) begin
      chk("rd_wen", 32'(bus.Rd_Wen), 32'(erw));
      chk("rs_wen", 32'(bus.Rs_Wen), 32'(esw));
    end
    @(posedge Clock);
    #1;
    chk("wen_cnt", 32'(wen_ev - w0),
        (erw || esw) ? 32'd1 : 32'd0);
    chk("rd_val", 32'(rf[rd]), 32'(mrf[rd]));
    chk("rs_val", 32'(rf[rs]), 32'(mrf[rs]));
    chk("flags", 32'(Flags), 32'(mfl));
  endtask

  initial begin
    int w0;
    bus.Instr_Valid = 1'b0;
    bus.Instr_Op    = '0;
    bus.Instr_Rd    = '0;
    bus.Instr_Rs    = '0;
    bus.Instr_Rm    = '0;
    bus.Instr_Imm   = '0;
    mfl = '0;
    for (int i = 0; i < 16; i++) begin
      rf[i]  = '0;
      mrf[i] = '0;
    end
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready", 32'(bus.Instr_Ready), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_flags", 32'(Flags), 32'd0);
    chk("rst_wen", 32'({bus.Rd_Wen, bus.Rs_Wen}), 32'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++)
      setreg(4'(i), 16'($urandom));

    setreg(2, 16'h0005);
    setreg(3, 16'h0007);
    issue(OP_ADD, 1, 2, 3, 0, 0);
    chk("add_r1", 32'(rf[1]), 32'h000C);
    chk("add_fl", 32'(Flags), 32'h0);

    setreg(2, 16'h0003);
    setreg(3, 16'h0005);
    issue(OP_SUB, 1, 2, 3, 0, 0);
    chk("sub_r1", 32'(rf[1]), 32'hFFFE);
    chk("sub_fl", 32'(Flags), 32'b1000);

    setreg(5, 16'h1234);
    setreg(3, 16'h0010);
    issue(OP_MUL, 4, 5, 3, 0, 0);
    chk("mul_hi", 32'(rf[4]), 32'h0001);
    chk("mul_lo", 32'(rf[5]), 32'h2340);

    setreg(6, 16'hAAAA);
    setreg(7, 16'h5555);
    issue(OP_SWP, 6, 7, 0, 0, 0);
    chk("swp_r6", 32'(rf[6]), 32'h5555);
    chk("swp_r7", 32'(rf[7]), 32'hAAAA);
    issue(OP_SWP, 6, 6, 0, 0, 0);
    issue(OP_MUL, 8, 8, 7, 0, 0);

    issue(OP_LDI, 9, 0, 0, 16'hBEEF, 1);
    issue(OP_MOV, 10, 0, 9, 0, 0);
    chk("b2b_r10", 32'(rf[10]), 32'hBEEF);

    setreg(2, 16'h0003);
    issue(OP_SUB, 1, 2, 3, 0, 0);
    chk("pre_rst_fl", 32'(Flags != 4'd0), 32'd1);
    @(negedge Clock);
    bus.Instr_Op    = OP_MUL;
    bus.Instr_Rd    = 11;
    bus.Instr_Rs    = 12;
    bus.Instr_Rm    = 13;
    bus.Instr_Valid = 1'b1;
    w0 = wen_ev;
    @(negedge Clock);
    bus.Instr_Valid = 1'b0;
    repeat (8) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("mrst_ready", 32'(bus.Instr_Ready), 32'd0);
    chk("mrst_done", 32'(Done), 32'd0);
    chk("mrst_flags", 32'(Flags), 32'd0);
    Reset_n = 1'b1;
    mfl = '0;
    @(negedge Clock);
    chk("mrst_rdy1", 32'(bus.Instr_Ready), 32'd1);
    repeat (25) @(negedge Clock);
    chk("mrst_nowen", 32'(wen_ev - w0), 32'd0);
    chk("mrst_r11", 32'(rf[11]), 32'(mrf[11]));
    chk("mrst_r12", 32'(rf[12]), 32'(mrf[12]));
    chk("mrst_fl2", 32'(Flags), 32'd0);

    repeat (80)
      issue(4'($urandom_range(0, 15)),
            4'($urandom), 4'($urandom),
            4'($urandom), 16'($urandom), 0);

    for (int i = 0; i < 16; i++)
      chk("final_rf", 32'(rf[i]), 32'(mrf[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
